// File: rtl/vdp_gamepad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vdp_gamepad_ctrl
// Description : Serial gamepad controller. Latches and clocks two PAD_BITS-wide
//               shift-register pads in parallel, captures their button states
//               and exposes them, together with a 4-bit LED register, over a
//               simple single-cycle register bus.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   1   system clock, rising edge
//   resetb     in   1   asynchronous active-low reset
//   bus_addr   in   2   word address: 0 CTRL/STATUS, 1 P1, 2 P2, 3 LED
//   bus_wdata  in   32  write data
//   bus_we     in   1   write strobe, qualified by bus_sel
//   bus_sel    in   1   bus cycle request
//   bus_rdata  out  32  read data, valid with bus_ack
//   bus_ack    out  1   acknowledge, one clock after bus_sel
//   pad_latch  out  1   pad load pulse (both pads)
//   pad_clk    out  1   pad shift clock (both pads), idles low
//   pad_p1_in  in   1   P1 serial data
//   pad_p2_in  in   1   P2 serial data
//   led        out  4   LED register
// ============================================================================
module vdp_gamepad_ctrl #(
  parameter int HALF_PERIOD = 8,
  parameter int PAD_BITS    = 12
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_sel,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad_p1_in,
  input  logic        pad_p2_in,
  output logic [3:0]  led
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BIT_W = $clog2(PAD_BITS + 1);

  localparam logic [CNT_W-1:0] c_phase_last = CNT_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] c_bit_last   = BIT_W'(PAD_BITS - 1);

  localparam logic [1:0] c_addr_ctrl = 2'd0;
  localparam logic [1:0] c_addr_p1   = 2'd1;
  localparam logic [1:0] c_addr_p2   = 2'd2;
  localparam logic [1:0] c_addr_led  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LOW    = 3'd3,
    ST_HIGH   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      phase_q,     phase_d;
  logic [BIT_W-1:0]      bit_q,       bit_d;
  logic [PAD_BITS-1:0]   sr1_q,       sr1_d;
  logic [PAD_BITS-1:0]   sr2_q,       sr2_d;
  logic [PAD_BITS-1:0]   p1_q,        p1_d;
  logic [PAD_BITS-1:0]   p2_q,        p2_d;
  logic                  valid_q,     valid_d;
  logic                  autopoll_q,  autopoll_d;
  logic [3:0]            led_q,       led_d;
  logic                  ack_q,       ack_d;
  logic [31:0]           rdata_q,     rdata_d;
  logic                  pad_latch_q, pad_latch_d;
  logic                  pad_clk_q,   pad_clk_d;
  logic                  p1_meta_q,   p1_meta_d;
  logic                  p1_sync_q,   p1_sync_d;
  logic                  p2_meta_q,   p2_meta_d;
  logic                  p2_sync_q,   p2_sync_d;

  logic                  w_wr;
  logic                  w_ctrl_wr;
  logic                  w_start;
  logic                  w_phase_last;
  logic                  w_busy;
  logic                  w_unused_wdata;

  // Only the low nibble of write data is architecturally meaningful.
  assign w_unused_wdata = ^bus_wdata[31:4];

  assign w_wr         = bus_sel & bus_we;
  assign w_ctrl_wr    = w_wr & (bus_addr == c_addr_ctrl);
  assign w_start      = (w_ctrl_wr & bus_wdata[0]) | autopoll_q;
  assign w_phase_last = (phase_q == c_phase_last);
  // DONE is the single hand-off cycle; the read is already complete there.
  assign w_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  always_comb begin
    p1_meta_d = pad_p1_in;
    p1_sync_d = p1_meta_q;
    p2_meta_d = pad_p2_in;
    p2_sync_d = p2_meta_q;
  end

  // --------------------------------------------------------------------------
  // Pad sequencing FSM: next state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + 1'b1;
    bit_d    = bit_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    valid_d  = valid_q;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        if (w_start) begin
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (w_phase_last) begin
          state_d = ST_SETTLE;
          phase_d = '0;
        end
      end

      ST_SETTLE: begin
        if (w_phase_last) begin
          state_d = ST_LOW;
          phase_d = '0;
        end
      end

      ST_LOW: begin
        // Sample at the very end of the low phase so the pad output has had
        // the whole phase (minus synchroniser delay) to settle.
        if (w_phase_last) begin
          sr1_d   = {p1_sync_q, sr1_q[PAD_BITS-1:1]};
          sr2_d   = {p2_sync_q, sr2_q[PAD_BITS-1:1]};
          state_d = ST_HIGH;
          phase_d = '0;
        end
      end

      ST_HIGH: begin
        // The rising edge after the final sample is still issued, so the pad
        // sees exactly PAD_BITS clocks per read.
        if (w_phase_last) begin
          bit_d   = bit_q + 1'b1;
          phase_d = '0;
          if (bit_q == c_bit_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOW;
          end
        end
      end

      ST_DONE: begin
        p1_d    = sr1_q;
        p2_d    = sr2_q;
        valid_d = 1'b1;
        phase_d = '0;
        bit_d   = '0;
        // Not busy here, so a start arriving now is honoured directly.
        state_d = w_start ? ST_LATCH : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Pad outputs are registered from the next state so they switch in the
  // same clock as the FSM and are glitch-free at the pad ring.
  always_comb begin
    pad_latch_d = (state_d == ST_LATCH);
    pad_clk_d   = (state_d == ST_HIGH);
  end

  // --------------------------------------------------------------------------
  // Register bus
  // --------------------------------------------------------------------------
  always_comb begin
    autopoll_d = autopoll_q;
    led_d      = led_q;
    ack_d      = bus_sel;
    rdata_d    = '0;

    if (w_ctrl_wr) begin
      autopoll_d = bus_wdata[1];
    end
    if (w_wr && (bus_addr == c_addr_led)) begin
      led_d = bus_wdata[3:0];
    end

    if (bus_sel && !bus_we) begin
      case (bus_addr)
        c_addr_ctrl: rdata_d = {29'd0, autopoll_q, valid_q, w_busy};
        c_addr_p1:   rdata_d = 32'(p1_q);
        c_addr_p2:   rdata_d = 32'(p2_q);
        c_addr_led:  rdata_d = {28'd0, led_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      sr1_q       <= '0;
      sr2_q       <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      valid_q     <= 1'b0;
      autopoll_q  <= 1'b0;
      led_q       <= 4'd0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
      p1_meta_q   <= 1'b0;
      p1_sync_q   <= 1'b0;
      p2_meta_q   <= 1'b0;
      p2_sync_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      sr1_q       <= sr1_d;
      sr2_q       <= sr2_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      valid_q     <= valid_d;
      autopoll_q  <= autopoll_d;
      led_q       <= led_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      p1_meta_q   <= p1_meta_d;
      p1_sync_q   <= p1_sync_d;
      p2_meta_q   <= p2_meta_d;
      p2_sync_q   <= p2_sync_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_gamepad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_gamepad_ctrl
// Description : Self-checking bench for vdp_gamepad_ctrl with two behavioural
//               shift-register pads and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_gamepad_ctrl;

  localparam int HP = 8;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic        bus_we = 1'b0;
  logic        bus_sel = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_p1_in;
  logic        pad_p2_in;
  logic [3:0]  led;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];

  vdp_gamepad_ctrl #(.HALF_PERIOD(HP), .PAD_BITS(12)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_sel   (bus_sel),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_p1_in (pad_p1_in),
    .pad_p2_in (pad_p2_in),
    .led       (led)
  );

  always #5 clock = ~clock;

  // Behavioural pads: load on latch rise, shift right on clock rise.
  logic [11:0] pad1_val = 12'h5A5;
  logic [11:0] pad2_val = 12'hC2C;
  logic [11:0] pad1_sr  = 12'h000;
  logic [11:0] pad2_sr  = 12'h000;

  always @(posedge pad_latch) begin
    pad1_sr = pad1_val;
    pad2_sr = pad2_val;
  end
  always @(posedge pad_clk) begin
    pad1_sr = {1'b1, pad1_sr[11:1]};
    pad2_sr = {1'b1, pad2_sr[11:1]};
  end
  assign pad_p1_in = pad1_sr[0];
  assign pad_p2_in = pad2_sr[0];

  // Edge and phase-width monitors.
  int cyc = 0;
  int lat_cnt = 0;
  int rise_cnt = 0;
  int lat_err = 0;
  int clk_err = 0;
  int lat_start = 0;
  int last_lat = -1000;
  int hi_start = 0;
  int last_rise = -1000;

  always @(posedge clock) cyc++;

  always @(posedge pad_latch) begin
    lat_cnt++;
    lat_start = cyc;
    last_lat  = cyc;
  end
  always @(negedge pad_latch) begin
    if (cyc - lat_start != HP) lat_err++;
  end
  always @(posedge pad_clk) begin
    if (last_rise > last_lat && (cyc - last_rise) != 2 * HP) clk_err++;
    last_rise = cyc;
    hi_start  = cyc;
    rise_cnt++;
  end
  always @(negedge pad_clk) begin
    if (cyc - hi_start != HP) clk_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic [1:0] a, input logic we, input logic [31:0] wd,
                          output logic [31:0] rd);
    @(negedge clock);
    bus_sel   = 1'b1;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
    @(posedge clock);
    #1;
    bus_sel = 1'b0;
    bus_we  = 1'b0;
    check("bus_ack", {31'd0, bus_ack}, 32'd1);
    rd = bus_rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] rd;
    bus_xfer(a, 1'b1, wd, rd);
  endtask

  task automatic sb_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic [31:0] e;
    exp_q.push_back(exp);
    bus_xfer(a, 1'b0, 32'd0, rd);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, rd, e);
    end
  endtask

  task automatic wait_idle();
    logic [31:0] rd;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      bus_xfer(2'd0, 1'b0, 32'd0, rd);
      if (rd[0] == 1'b0) done = 1'b1;
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int lat0, rise0, lerr0, cerr0;
    logic ok;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #1;
    check("rst_pad_latch", {31'd0, pad_latch}, 32'd0);
    check("rst_pad_clk",   {31'd0, pad_clk},   32'd0);
    check("rst_led",       {28'd0, led},       32'd0);
    check("rst_ack",       {31'd0, bus_ack},   32'd0);
    check("rst_rdata",     bus_rdata,          32'd0);
    @(negedge clock);
    resetb = 1'b1;
    sb_read("rst_ctrl", 2'd0, 32'd0);
    sb_read("rst_p1",   2'd1, 32'd0);
    sb_read("rst_p2",   2'd2, 32'd0);
    @(posedge clock); #1;
    check("ack_idle_low", {31'd0, bus_ack}, 32'd0);

    // ---------------- LED register ----------------
    begin
      logic [3:0] led_seq [6] = '{4'h5, 4'hA, 4'h5, 4'hC, 4'h2, 4'hC};
      for (int i = 0; i < 6; i++) begin
        bus_write(2'd3, {28'hFFFFFFF, led_seq[i]});
        check("led_out", {28'd0, led}, {28'd0, led_seq[i]});
        sb_read("led_rd", 2'd3, {28'd0, led_seq[i]});
      end
    end

    // ---------------- basic read ----------------
    lat0 = lat_cnt; rise0 = rise_cnt; lerr0 = lat_err; cerr0 = clk_err;
    bus_write(2'd0, 32'd1);
    sb_read("ctrl_busy", 2'd0, 32'h1);
    wait_idle();
    sb_read("rd1_p1", 2'd1, 32'h5A5);
    sb_read("rd1_p2", 2'd2, 32'hC2C);
    sb_read("rd1_ctrl", 2'd0, 32'h2);
    check("rd1_latches", lat_cnt - lat0,   32'd1);
    check("rd1_rises",   rise_cnt - rise0, 32'd12);
    check("rd1_lat_w",   lat_err - lerr0,  32'd0);
    check("rd1_clk_w",   clk_err - cerr0,  32'd0);
    check("rd1_clk_idle", {31'd0, pad_clk}, 32'd0);

    // ---------------- starts while busy ----------------
    lat0 = lat_cnt; rise0 = rise_cnt;
    pad1_val = 12'h123;
    pad2_val = 12'hFED;
    bus_write(2'd0, 32'd1);
    bus_write(2'd0, 32'd1);
    repeat (20) @(posedge clock);
    bus_write(2'd0, 32'd1);
    wait_idle();
    check("dbl_latches", lat_cnt - lat0,   32'd1);
    check("dbl_rises",   rise_cnt - rise0, 32'd12);
    sb_read("dbl_p1", 2'd1, 32'h123);
    sb_read("dbl_p2", 2'd2, 32'hFED);
    pad1_val = 12'h5A5;
    pad2_val = 12'hC2C;

    // ---------------- reset mid-read ----------------
    bus_write(2'd3, 32'hF);
    rise0 = rise_cnt;
    bus_write(2'd0, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clock);
      if (rise_cnt - rise0 >= 6) ok = 1'b1;
    end
    check("mid_wait", {31'd0, ok}, 32'd1);
    @(posedge clock);
    #3;
    resetb = 1'b0;
    #1;
    check("mid_rst_latch", {31'd0, pad_latch}, 32'd0);
    check("mid_rst_clk",   {31'd0, pad_clk},   32'd0);
    check("mid_rst_led",   {28'd0, led},       32'd0);
    check("mid_rst_rdata", bus_rdata,          32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetb = 1'b1;
    sb_read("mid_p1",   2'd1, 32'd0);
    sb_read("mid_p2",   2'd2, 32'd0);
    sb_read("mid_ctrl", 2'd0, 32'd0);
    lat0 = lat_cnt; rise0 = rise_cnt; lerr0 = lat_err; cerr0 = clk_err;
    bus_write(2'd0, 32'd1);
    wait_idle();
    sb_read("fresh_p1", 2'd1, 32'h5A5);
    sb_read("fresh_p2", 2'd2, 32'hC2C);
    sb_read("fresh_ctrl", 2'd0, 32'h2);
    check("fresh_latches", lat_cnt - lat0,   32'd1);
    check("fresh_rises",   rise_cnt - rise0, 32'd12);
    check("fresh_clk_w",   clk_err - cerr0,  32'd0);

    // ---------------- autopoll ----------------
    lat0 = lat_cnt;
    bus_write(2'd0, 32'd2);
    pad1_val = 12'hFFF;
    pad2_val = 12'h000;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clock);
      if (lat_cnt - lat0 >= 2) ok = 1'b1;
    end
    check("auto_wait", {31'd0, ok}, 32'd1);
    sb_read("auto_p1",   2'd1, 32'hFFF);
    sb_read("auto_p2",   2'd2, 32'h000);
    sb_read("auto_ctrl", 2'd0, 32'h7);
    sb_read("auto_led",  2'd3, 32'd0);
    bus_write(2'd0, 32'd0);
    wait_idle();
    sb_read("auto_off_ctrl", 2'd0, 32'h2);
    sb_read("auto_off_p1",   2'd1, 32'hFFF);
    sb_read("auto_off_p2",   2'd2, 32'h000);
    check("auto_clk_idle", {31'd0, pad_clk}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
